// File: rtl/collision_pkg.sv
// Shared types and sizing for the per-frame dragon collision scan.
package collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam int DEFAULT_POS_W        = 8;
    localparam int DEFAULT_NUM_SEGMENTS = 7;
    localparam int SEG_IDX_W            = 3;
    localparam int LIVES_W              = 2;

endpackage

// File: rtl/collision_sequencer_matcher.sv
// Combinational overlap test of one dragon segment against the player, sword and sheep.
module segment_matcher
    import collision_pkg::*;
#(
    parameter int POS_W = DEFAULT_POS_W
) (
    input  logic [POS_W-1:0] seg_pos,
    input  logic             seg_active,
    input  logic [POS_W-1:0] player_pos,
    input  logic [POS_W-1:0] sword_pos,
    input  logic             sword_active,
    input  logic [POS_W-1:0] sheep_pos,
    output logic             player_match,
    output logic             sword_match,
    output logic             sheep_match
);

    assign player_match = seg_active && (seg_pos == player_pos);
    assign sword_match  = seg_active && sword_active && (seg_pos == sword_pos);
    assign sheep_match  = seg_active && (seg_pos == sheep_pos);

endmodule

// File: rtl/collision_sequencer.sv
// Frame collision controller: snapshots positions, scans one dragon segment per cycle,
// then resolves hits into lives / game-over and pulses done.
module collision_sequencer
    import collision_pkg::*;
#(
    parameter int NUM_SEGMENTS  = DEFAULT_NUM_SEGMENTS,
    parameter int POS_W         = DEFAULT_POS_W,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [POS_W-1:0]              player_pos,
    input  logic [POS_W-1:0]              sword_pos,
    input  logic                          sword_active,
    input  logic [POS_W-1:0]              sheep_pos,
    input  logic [NUM_SEGMENTS*POS_W-1:0] dragon_positions,
    input  logic [NUM_SEGMENTS-1:0]       dragon_active,
    output logic                          busy,
    output logic                          done,
    output logic                          player_hit,
    output logic                          sword_hit,
    output logic [SEG_IDX_W-1:0]          sword_seg_idx,
    output logic                          sheep_hit,
    output logic [LIVES_W-1:0]            lives,
    output logic                          game_over,
    output logic                          overrun
);

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);

    state_t                        state_r, state_s;
    logic [SEG_IDX_W-1:0]          idx_r, idx_s;
    logic [INV_W-1:0]              inv_r, inv_s;
    logic [POS_W-1:0]              player_snap_r, player_snap_s;
    logic [POS_W-1:0]              sword_snap_r, sword_snap_s;
    logic                          sword_act_snap_r, sword_act_snap_s;
    logic [POS_W-1:0]              sheep_snap_r, sheep_snap_s;
    logic [NUM_SEGMENTS*POS_W-1:0] dragon_snap_r, dragon_snap_s;
    logic [NUM_SEGMENTS-1:0]       active_snap_r, active_snap_s;
    logic                          player_acc_r, player_acc_s;
    logic                          sword_acc_r, sword_acc_s;
    logic                          sheep_acc_r, sheep_acc_s;
    logic [SEG_IDX_W-1:0]          sword_idx_acc_r, sword_idx_acc_s;
    logic                          player_hit_s, sword_hit_s, sheep_hit_s;
    logic [SEG_IDX_W-1:0]          sword_seg_idx_s;
    logic [LIVES_W-1:0]            lives_s;
    logic                          busy_s, done_s, game_over_s, overrun_s;
    logic                          player_match_s, sword_match_s, sheep_match_s;

    segment_matcher #(.POS_W(POS_W)) u_matcher (
        .seg_pos      (dragon_snap_r[idx_r*POS_W +: POS_W]),
        .seg_active   (active_snap_r[idx_r]),
        .player_pos   (player_snap_r),
        .sword_pos    (sword_snap_r),
        .sword_active (sword_act_snap_r),
        .sheep_pos    (sheep_snap_r),
        .player_match (player_match_s),
        .sword_match  (sword_match_s),
        .sheep_match  (sheep_match_s)
    );

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_s          = state_r;
        idx_s            = idx_r;
        inv_s            = inv_r;
        player_snap_s    = player_snap_r;
        sword_snap_s     = sword_snap_r;
        sword_act_snap_s = sword_act_snap_r;
        sheep_snap_s     = sheep_snap_r;
        dragon_snap_s    = dragon_snap_r;
        active_snap_s    = active_snap_r;
        player_acc_s     = player_acc_r;
        sword_acc_s      = sword_acc_r;
        sheep_acc_s      = sheep_acc_r;
        sword_idx_acc_s  = sword_idx_acc_r;
        player_hit_s     = player_hit;
        sword_hit_s      = sword_hit;
        sword_seg_idx_s  = sword_seg_idx;
        sheep_hit_s      = sheep_hit;
        lives_s          = lives;
        overrun_s        = overrun;
        done_s           = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    player_snap_s    = player_pos;
                    sword_snap_s     = sword_pos;
                    sword_act_snap_s = sword_active;
                    sheep_snap_s     = sheep_pos;
                    dragon_snap_s    = dragon_positions;
                    active_snap_s    = dragon_active;
                    player_acc_s     = 1'b0;
                    sword_acc_s      = 1'b0;
                    sheep_acc_s      = 1'b0;
                    sword_idx_acc_s  = {SEG_IDX_W{1'b0}};
                    idx_s            = {SEG_IDX_W{1'b0}};
                    state_s          = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (frame_start) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun;
                end
                player_acc_s = player_acc_r | player_match_s;
                sheep_acc_s  = sheep_acc_r | sheep_match_s;
                // Only the first sword match records its index.
                if (sword_match_s && !sword_acc_r) begin
                    sword_acc_s     = 1'b1;
                    sword_idx_acc_s = idx_r;
                end else begin
                    sword_acc_s     = sword_acc_r;
                end
                if (idx_r == SEG_IDX_W'(NUM_SEGMENTS - 1)) begin
                    state_s = ST_RESOLVE;
                end else begin
                    idx_s = idx_r + SEG_IDX_W'(1);
                end
            end
            ST_RESOLVE: begin
                if (frame_start) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun;
                end
                player_hit_s    = player_acc_r;
                sword_hit_s     = sword_acc_r;
                sword_seg_idx_s = sword_idx_acc_r;
                sheep_hit_s     = sheep_acc_r;
                done_s          = 1'b1;
                if (player_acc_r && (inv_r == {INV_W{1'b0}})) begin
                    if (lives != {LIVES_W{1'b0}}) begin
                        lives_s = lives - LIVES_W'(1);
                    end else begin
                        lives_s = lives;
                    end
                    inv_s = INV_W'(INVULN_FRAMES);
                end else if (inv_r != {INV_W{1'b0}}) begin
                    inv_s = inv_r - INV_W'(1);
                end else begin
                    inv_s = inv_r;
                end
                if (lives_s == {LIVES_W{1'b0}}) begin
                    state_s = ST_OVER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OVER: begin
                state_s = ST_OVER;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s      = (state_s == ST_SCAN) || (state_s == ST_RESOLVE);
        game_over_s = (state_s == ST_OVER);
    end

    // State, snapshot, accumulator and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            idx_r            <= {SEG_IDX_W{1'b0}};
            inv_r            <= {INV_W{1'b0}};
            player_snap_r    <= {POS_W{1'b0}};
            sword_snap_r     <= {POS_W{1'b0}};
            sword_act_snap_r <= 1'b0;
            sheep_snap_r     <= {POS_W{1'b0}};
            dragon_snap_r    <= {(NUM_SEGMENTS*POS_W){1'b0}};
            active_snap_r    <= {NUM_SEGMENTS{1'b0}};
            player_acc_r     <= 1'b0;
            sword_acc_r      <= 1'b0;
            sheep_acc_r      <= 1'b0;
            sword_idx_acc_r  <= {SEG_IDX_W{1'b0}};
            busy             <= 1'b0;
            done             <= 1'b0;
            player_hit       <= 1'b0;
            sword_hit        <= 1'b0;
            sword_seg_idx    <= {SEG_IDX_W{1'b0}};
            sheep_hit        <= 1'b0;
            lives            <= LIVES_W'(LIVES_INIT);
            game_over        <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            state_r          <= state_s;
            idx_r            <= idx_s;
            inv_r            <= inv_s;
            player_snap_r    <= player_snap_s;
            sword_snap_r     <= sword_snap_s;
            sword_act_snap_r <= sword_act_snap_s;
            sheep_snap_r     <= sheep_snap_s;
            dragon_snap_r    <= dragon_snap_s;
            active_snap_r    <= active_snap_s;
            player_acc_r     <= player_acc_s;
            sword_acc_r      <= sword_acc_s;
            sheep_acc_r      <= sheep_acc_s;
            sword_idx_acc_r  <= sword_idx_acc_s;
            busy             <= busy_s;
            done             <= done_s;
            player_hit       <= player_hit_s;
            sword_hit        <= sword_hit_s;
            sword_seg_idx    <= sword_seg_idx_s;
            sheep_hit        <= sheep_hit_s;
            lives            <= lives_s;
            game_over        <= game_over_s;
            overrun          <= overrun_s;
        end
    end

endmodule

// File: tb/tb_collision_sequencer.sv
// Directed-vector bench for collision_sequencer; expected values are hand-derived.
module tb_collision_sequencer;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [7:0]  player_pos;
    logic [7:0]  sword_pos;
    logic        sword_active;
    logic [7:0]  sheep_pos;
    logic [55:0] dragon_positions;
    logic [6:0]  dragon_active;
    logic        busy, done, player_hit, sword_hit, sheep_hit, game_over, overrun;
    logic [2:0]  sword_seg_idx;
    logic [1:0]  lives;

    int total = 0;
    int bad   = 0;
    int first_done, done_cnt, busy_cnt;

    collision_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .player_pos       (player_pos),
        .sword_pos        (sword_pos),
        .sword_active     (sword_active),
        .sheep_pos        (sheep_pos),
        .dragon_positions (dragon_positions),
        .dragon_active    (dragon_active),
        .busy             (busy),
        .done             (done),
        .player_hit       (player_hit),
        .sword_hit        (sword_hit),
        .sword_seg_idx    (sword_seg_idx),
        .sheep_hit        (sheep_hit),
        .lives            (lives),
        .game_over        (game_over),
        .overrun          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Segment k sits at 0x80+k; player/sword/sheep park at non-colliding spots.
    task automatic set_defaults();
        for (int k = 0; k < 7; k++) dragon_positions[k*8 +: 8] = 8'h80 + 8'(k);
        dragon_active = 7'h7F;
        player_pos    = 8'h01;
        sword_pos     = 8'h02;
        sword_active  = 1'b0;
        sheep_pos     = 8'h03;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Pulse frame_start, then watch n cycles; optional second pulse and mid-scan input change.
    task automatic run_cycles(input int n, input int fs2_at, input int chg_at,
                              output int fd, output int dc, output int bc);
        fd = -1;
        dc = 0;
        bc = 0;
        frame_start = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dc++;
                if (fd < 0) fd = i;
            end
            frame_start = (i == fs2_at);
            if (i == chg_at) begin
                player_pos   = 8'h01;
                sword_pos    = 8'h81;
                sword_active = 1'b1;
            end
        end
    endtask

    task automatic frame(output int fd, output int dc, output int bc);
        run_cycles(14, -1, -1, fd, dc, bc);
    endtask

    initial begin
        frame_start = 1'b0;
        set_defaults();
        reset = 1'b0;
        @(negedge clk);
        do_reset();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_lives", 32'(lives), 32'd3);
        check_val("rst_over", 32'(game_over), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        check_val("rst_hits", {29'd0, player_hit, sword_hit, sheep_hit}, 32'd0);

        // Player on segment 3
        dragon_positions[3*8 +: 8] = 8'h45;
        player_pos = 8'h45;
        frame(first_done, done_cnt, busy_cnt);
        check_val("t1_latency", 32'(first_done), 32'd9);
        check_val("t1_done_cnt", 32'(done_cnt), 32'd1);
        check_val("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        check_val("t1_player_hit", 32'(player_hit), 32'd1);
        check_val("t1_other_hits", {30'd0, sword_hit, sheep_hit}, 32'd0);
        check_val("t1_lives", 32'(lives), 32'd2);
        set_defaults();

        // Sword on segments 2 and 5: lowest index wins
        sword_pos = 8'h22;
        sword_active = 1'b1;
        dragon_positions[2*8 +: 8] = 8'h22;
        dragon_positions[5*8 +: 8] = 8'h22;
        frame(first_done, done_cnt, busy_cnt);
        check_val("t2_sword_hit", 32'(sword_hit), 32'd1);
        check_val("t2_sword_idx", 32'(sword_seg_idx), 32'd2);
        check_val("t2_player_hit", 32'(player_hit), 32'd0);
        sword_active = 1'b0;
        frame(first_done, done_cnt, busy_cnt);
        check_val("t2_sword_off", 32'(sword_hit), 32'd0);
        check_val("t2_sword_idx0", 32'(sword_seg_idx), 32'd0);
        set_defaults();

        // Sheep on segment 6, masked then unmasked
        sheep_pos = 8'h66;
        dragon_positions[6*8 +: 8] = 8'h66;
        dragon_active = 7'h3F;
        frame(first_done, done_cnt, busy_cnt);
        check_val("t3_sheep_masked", 32'(sheep_hit), 32'd0);
        dragon_active = 7'h7F;
        frame(first_done, done_cnt, busy_cnt);
        check_val("t3_sheep_hit", 32'(sheep_hit), 32'd1);
        // All segments inactive while everything overlaps
        player_pos = 8'h66;
        sword_pos = 8'h66;
        sword_active = 1'b1;
        dragon_active = 7'h00;
        frame(first_done, done_cnt, busy_cnt);
        check_val("t3_all_inactive", {29'd0, player_hit, sword_hit, sheep_hit}, 32'd0);
        check_val("t3_lives", 32'(lives), 32'd2);
        set_defaults();

        // Invulnerability window: hits on six consecutive frames
        do_reset();
        dragon_positions[4*8 +: 8] = 8'h45;
        player_pos = 8'h45;
        for (int f = 1; f <= 5; f++) begin
            frame(first_done, done_cnt, busy_cnt);
            check_val($sformatf("t4_lives_f%0d", f), 32'(lives), 32'd2);
        end
        sword_pos = 8'h45;
        sword_active = 1'b1;
        sheep_pos = 8'h45;
        frame(first_done, done_cnt, busy_cnt);
        check_val("t4_lives_f6", 32'(lives), 32'd1);
        check_val("t4_all_hits", {29'd0, player_hit, sword_hit, sheep_hit}, 32'd7);
        check_val("t4_sword_idx", 32'(sword_seg_idx), 32'd4);
        set_defaults();

        // frame_start in the done cycle is accepted
        do_reset();
        run_cycles(22, 9, -1, first_done, done_cnt, busy_cnt);
        check_val("bb_done_cnt", 32'(done_cnt), 32'd2);
        check_val("bb_overrun", 32'(overrun), 32'd0);

        // Overrun plus mid-scan input change
        player_pos = 8'h80;
        run_cycles(20, 3, 2, first_done, done_cnt, busy_cnt);
        check_val("t5_done_cnt", 32'(done_cnt), 32'd1);
        check_val("t5_latency", 32'(first_done), 32'd9);
        check_val("t5_overrun", 32'(overrun), 32'd1);
        check_val("t5_snap_player", 32'(player_hit), 32'd1);
        check_val("t5_snap_sword", 32'(sword_hit), 32'd0);
        set_defaults();
        frame(first_done, done_cnt, busy_cnt);
        check_val("t5_overrun_sticky", 32'(overrun), 32'd1);

        // Drive lives to zero: hits land on frames 1, 6 and 11
        do_reset();
        player_pos = 8'h80;
        for (int f = 1; f <= 11; f++) frame(first_done, done_cnt, busy_cnt);
        check_val("t6_last_done", 32'(done_cnt), 32'd1);
        check_val("t6_lives0", 32'(lives), 32'd0);
        check_val("t6_game_over", 32'(game_over), 32'd1);
        frame(first_done, done_cnt, busy_cnt);
        check_val("t6_over_no_done", 32'(done_cnt), 32'd0);
        check_val("t6_over_no_busy", 32'(busy_cnt), 32'd0);
        check_val("t6_over_no_overrun", 32'(overrun), 32'd0);
        check_val("t6_over_lives", 32'(lives), 32'd0);

        // Reset in the middle of a scan
        do_reset();
        frame(first_done, done_cnt, busy_cnt);
        check_val("t6_pre_hit", 32'(player_hit), 32'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("t6_mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_lives", 32'(lives), 32'd3);
        check_val("t6_rst_hits", {29'd0, player_hit, sword_hit, sheep_hit}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_val("t6_rst_no_done", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collision_sequencer.md
Name: collision_sequencer

Overview:
- Frame-level controller that owns the per-frame dragon collision scan.
- On each frame_start it snapshots the player, sword, sheep and dragon positions, then walks the active dragon segments one per cycle through a shared comparator stage.
- It resolves the accumulated hits into per-frame results, lives and game-over state, and signals completion with a one-cycle done pulse to the game logic.

Parameters:
- NUM_SEGMENTS, 7, number of dragon segments scanned per frame.
- POS_W, 8, position width ({row,col} packed).
- LIVES_INIT, 3, lives loaded at reset; must be ≤ 3.
- INVULN_FRAMES, 4, frames after a player hit during which further player hits do not cost a life.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- frame_start  in  1  one-cycle pulse requesting a scan.
- player_pos  in  POS_W  player position.
- sword_pos  in  POS_W  sword position.
- sword_active  in  1  sword currently deployed.
- sheep_pos  in  POS_W  sheep position.
- dragon_positions  in  NUM_SEGMENTS*POS_W  segment k at bits [k*POS_W +: POS_W].
- dragon_active  in  NUM_SEGMENTS  bit k = segment k valid.
- busy  out  1  scan in progress.
- done  out  1  one-cycle results-valid pulse.
- player_hit  out  1  player overlapped an active segment this frame.
- sword_hit  out  1  active sword overlapped an active segment.
- sword_seg_idx  out  3  lowest segment index hit by the sword; 0 if none.
- sheep_hit  out  1  sheep overlapped an active segment.
- lives  out  2  remaining lives.
- game_over  out  1  lives reached 0.
- overrun  out  1  sticky: frame_start arrived while busy.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, lives=LIVES_INIT, invulnerability counter=0. All other outputs 0. Applies mid-scan and aborts the scan with no result.
- States: IDLE, SCAN, RESOLVE, OVER.
- IDLE, frame_start=1 at cycle 0:
  - Register all position and active inputs into snapshots.
  - Clear hit accumulators; segment index=0.
  - Go to SCAN.
- SCAN, cycles 1..NUM_SEGMENTS:
  - Each cycle compares snapshot segment[idx] against the player, sword and sheep snapshots.
  - A match counts only if dragon_active[idx]=1; a sword match also requires the sword_active snapshot.
  - Results OR into accumulators. The first sword match latches idx; later matches do not overwrite it.
  - After idx==NUM_SEGMENTS-1, go to RESOLVE.
- RESOLVE, cycle NUM_SEGMENTS+1:
  - Copy accumulators to player_hit, sword_hit, sword_seg_idx and sheep_hit.
  - If player_hit and invulnerability counter==0: lives-=1 and counter=INVULN_FRAMES.
  - Otherwise, if counter>0: counter-=1, once per resolved frame.
  - If lives becomes 0: go to OVER; otherwise go to IDLE.
- Result timing:
  - Outputs and done become valid in cycle NUM_SEGMENTS+2, i.e. 9 cycles after frame_start with defaults.
  - done is high for exactly that one cycle.
  - Hit outputs hold until the next RESOLVE.
- busy: high in SCAN and RESOLVE only.
- A frame_start in the done cycle is accepted (state is IDLE then).
- frame_start while busy is ignored and sets overrun, which stays set until reset.
- Input changes after the snapshot do not affect the current scan.
- lives never underflows. When lives reaches 0 it enters OVER:
  - game_over=1.
  - frame_start is ignored with no done and no overrun.
  - Exit only via reset.
- Simultaneous player, sword and sheep hits in one frame are all reported independently.
- All-inactive dragon_active gives no hits regardless of positions.

Decomposition:
- Package collision_pkg holds:
  - state enum (IDLE, SCAN, RESOLVE, OVER);
  - POS_W and NUM_SEGMENTS defaults;
  - SEG_IDX_W=3;
  - LIVES_W=2.
- One sub-module, segment_matcher: combinational compare of one segment against the three snapshots, gated by the active bits. Outputs three match flags.

Test Plan:
1. Player and segment 3 both at 0x45, dragon_active=7'h7F, one frame_start → done exactly 9 cycles later; player_hit=1; lives 3→2; busy high 8 cycles.
2. Sword_active=1, sword_pos=0x22 matching segments 2 and 5 → sword_hit=1, sword_seg_idx=2. Repeat with sword_active=0 → sword_hit=0.
3. Sheep matches segment 6 only, but dragon_active[6]=0 → sheep_hit=0. Set bit 6 → sheep_hit=1.
4. Player collides on 5 consecutive frames, INVULN_FRAMES=4 → lives decrements only on frame 1 (3→2); decrements again on frame 6 (2→1).
5. Second frame_start 3 cycles after the first → ignored; overrun=1; only one done. Positions changed mid-scan → results reflect the snapshot.
6. Lives driven to 0 → game_over=1 and later frame_start gives no done. reset=0 during SCAN → next cycle busy=0, lives=3, all hits 0.
